// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: word-organised data RAM slave for the core dbus with byte-lane
// stores, programmable wait states and a registered one-cycle ready/err completion pulse.
module dbus_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_we,
    input  logic        dbus_re,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ready,
    output logic        dbus_err,
    output logic        busy
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_RESP  = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_re;
    logic          r_we;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_idle;
    logic          w_req;
    logic          w_commit;
    logic          w_err;
    logic          w_store;
    logic          w_re;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_next;

    // With zero wait states the commit happens on the accepting edge, so the live request
    // stands in for the latched copy while in IDLE.
    assign w_idle   = r_state == S_IDLE;
    assign w_req    = dbus_re | dbus_we;
    assign w_addr   = w_idle ? dbus_addr  : r_addr;
    assign w_wdata  = w_idle ? dbus_wdata : r_wdata;
    assign w_be     = w_idle ? dbus_be    : r_be;
    assign w_re     = w_idle ? dbus_re    : r_re;
    assign w_we     = w_idle ? dbus_we    : r_we;
    assign w_commit = w_idle ? (w_req && WAIT_STATES == 0) : (r_state == S_WAIT && r_cnt == 4'd0);
    assign w_err    = (w_re & w_we) | (w_addr[1:0] != 2'd0) | (w_we & (w_be == 4'd0)) |
                      (w_addr < BASE_ADDR) | ({1'b0, w_addr} >= LIMIT);
    assign w_idx    = AW'((w_addr - BASE_ADDR) >> 2);
    assign w_store  = rst_n & w_commit & ~w_err & w_we;
    assign w_next   = w_idle ? (w_req ? ((WAIT_STATES == 0) ? S_RESP : S_WAIT) : S_IDLE) :
                      (r_state == S_WAIT) ? ((r_cnt == 4'd0) ? S_RESP : S_WAIT) : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            dbus_rdata <= 32'd0;
            dbus_ready <= 1'b0;
            dbus_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_next;
            dbus_ready <= w_commit;
            dbus_err   <= w_commit & w_err;
            busy       <= w_next != S_IDLE;
            if (w_idle && w_req) begin
                r_addr  <= dbus_addr;
                r_wdata <= dbus_wdata;
                r_be    <= dbus_be;
                r_re    <= dbus_re;
                r_we    <= dbus_we;
                r_cnt   <= WS_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && (w_err || !w_we))
                dbus_rdata <= w_err ? 32'd0 : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_store)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder: scoreboard bench over three responders with 0, 1 and 15 wait states
// sharing address/data/reset; each instance has its own request strobes.
module tb_dbus_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        re [3];
    logic        we [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err [3];
    logic        busy [3];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    dbus_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .dbus_addr(addr), .dbus_wdata(wdata), .dbus_be(be),
        .dbus_we(we[0]), .dbus_re(re[0]), .dbus_rdata(rdata[0]), .dbus_ready(ready[0]),
        .dbus_err(err[0]), .busy(busy[0]));
    dbus_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .dbus_addr(addr), .dbus_wdata(wdata), .dbus_be(be),
        .dbus_we(we[1]), .dbus_re(re[1]), .dbus_rdata(rdata[1]), .dbus_ready(ready[1]),
        .dbus_err(err[1]), .busy(busy[1]));
    dbus_mem_responder #(.WAIT_STATES(15)) u_ws15 (
        .clk(clk), .rst_n(rst_n), .dbus_addr(addr), .dbus_wdata(wdata), .dbus_be(be),
        .dbus_we(we[2]), .dbus_re(re[2]), .dbus_rdata(rdata[2]), .dbus_ready(ready[2]),
        .dbus_err(err[2]), .busy(busy[2]));

    // Called at posedge+1 with the target idle; pushes the expectation, runs one access and
    // returns what the DUT produced. Leaves the target idle at posedge+1.
    task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input logic [31:0] erd,
                        input logic eer, input int elat,
                        output logic [31:0] rd, output logic er, output int lat);
        q.push_back('{erd, eer, elat});
        addr = a; wdata = wd; be = b; re[d] = r; we[d] = w; lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ready[d] && lat < 40);
        rd = rdata[d]; er = err[d];
        re[d] = 1'b0; we[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat; exp_t e;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({rdata[d], ready[d], err[d], busy[d]} !== 35'd0) begin
                fails++;
                $display("FAIL reset_out[%0d]: got rdata=%h ready=%b err=%b busy=%b, want all 0",
                         d, rdata[d], ready[d], err[d], busy[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, 32'd0, 1'b0, 2, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL reset_prestore: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
        addr = 32'h0001_0000; wdata = 32'hFFFF_FFFF; be = 4'hF; we[1] = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy_wait: got %b, want 1", busy[1]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rdata[1], ready[1], err[1], busy[1]} !== 35'd0) begin
            fails++;
            $display("FAIL reset_midwait: got rdata=%h ready=%b err=%b busy=%b, want all 0",
                     rdata[1], ready[1], err[1], busy[1]);
        end
        we[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 2, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL reset_abandon: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; exp_t e;
        xfer(1, 1'b0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b0, 2, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL store_ws1: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
        xfer(1, 1'b1, 1'b0, 32'h0001_0004, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL load_ws1: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat; exp_t e;
        logic [31:0] wds [3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0};
        logic [3:0]  bes [3] = '{4'hF, 4'b0101, 4'h0};
        logic [31:0] exps [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h11BB_33DD};
        for (int i = 0; i < 3; i++) begin
            xfer(1, i == 2, i != 2, 32'h0001_0008, wds[i], bes[i], exps[i], 1'b0, 2, rd, er, lat);
            e = q.pop_front(); tests++;
            if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
                fails++;
                $display("FAIL byte_lanes[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                         i, er, rd, lat, e.er, e.rd, e.lat);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; exp_t e;
        logic        ers [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ews [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] eas [7] = '{32'h0001_0002, 32'h0000_FFFC, 32'h0001_1000, 32'h0001_0004,
                                 32'h0001_0004, 32'h0001_0006, 32'h0001_1000};
        logic [3:0]  ebs [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF};
        for (int i = 0; i < 7; i++) begin
            xfer(1, 1'b1, 1'b0, 32'h0001_0004, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, rd, er, lat);
            e = q.pop_front(); tests++;
            if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
                fails++;
                $display("FAIL err_intact[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                         i, er, rd, lat, e.er, e.rd, e.lat);
            end
            xfer(1, ers[i], ews[i], eas[i], 32'h5555_0000, ebs[i], 32'd0, 1'b1, 2, rd, er, lat);
            e = q.pop_front(); tests++;
            if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
                fails++;
                $display("FAIL err_case[%0d]: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                         i, er, rd, lat, e.er, e.rd, e.lat);
            end
        end
        xfer(1, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 2, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL err_no_alias: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; exp_t e; logic exp_rdy;
        xfer(0, 1'b0, 1'b1, 32'h0001_0010, 32'h0102_0304, 4'hF, 32'd0, 1'b0, 1, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL b2b_store_ws0: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
        for (int i = 0; i < 3; i++) q.push_back('{32'h0102_0304, 1'b0, 1});
        addr = 32'h0001_0010; re[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k % 2 == 1) && (k <= 5);
            tests++;
            if ({ready[0], busy[0], err[0]} !== {exp_rdy, exp_rdy, 1'b0}) begin
                fails++;
                $display("FAIL b2b_cycle[%0d]: got ready=%b busy=%b err=%b, want ready=%b busy=%b err=0",
                         k, ready[0], busy[0], err[0], exp_rdy, exp_rdy);
            end
            if (ready[0]) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra[%0d]: got unexpected ready pulse, want none", k);
                end else begin
                    e = q.pop_front();
                    if (rdata[0] !== e.rd) begin
                        fails++;
                        $display("FAIL b2b_rdata[%0d]: got %h, want %h", k, rdata[0], e.rd);
                    end
                end
            end
            if (k == 5) re[0] = 1'b0;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL b2b_missing: got %0d responses left, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; logic er; int lat; exp_t e;
        xfer(2, 1'b0, 1'b1, 32'h0001_0FFC, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 16, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL bound_store_ws15: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
        xfer(2, 1'b1, 1'b0, 32'h0001_0FFC, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, 16, rd, er, lat);
        e = q.pop_front(); tests++;
        if ({er, rd, lat} !== {e.er, e.rd, e.lat}) begin
            fails++;
            $display("FAIL bound_load_ws15: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                     er, rd, lat, e.er, e.rd, e.lat);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            re[d] = 1'b0;
            we[d] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
